// File: rtl/types_pkg.sv
// Shared datapath types for the operand stage and the ALU it feeds.
package types_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] DATA_BUS;

  typedef enum logic [2:0] {
    SUM_OP = 3'd0,
    SUB_OP = 3'd1,
    AND_OP = 3'd2,
    OR_OP  = 3'd3,
    XOR_OP = 3'd4,
    SLT_OP = 3'd5,
    SLL_OP = 3'd6,
    SRL_OP = 3'd7
  } alu_ctrl;

endpackage

// File: rtl/operand_stage.sv
// Decode/issue stage: architectural register file with write-through bypass,
// second-operand select, and the ID/EX pipeline register feeding the ALU.
module operand_stage
  import types_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  input  DATA_BUS               imm,
  input  logic                  alu_src,
  input  alu_ctrl               alu_ctrl_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  DATA_BUS               wb_data,
  output DATA_BUS               ALUop1,
  output DATA_BUS               ALUop2,
  output alu_ctrl               ALUctrl,
  output DATA_BUS               store_data,
  output logic [ADDR_WIDTH-1:0] rd_out,
  output logic                  ex_valid,
  output DATA_BUS               a0
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int unsigned A0_IDX   = 10;

  DATA_BUS               r_regs [NUM_REGS];
  DATA_BUS               r_op1;
  DATA_BUS               r_op2;
  DATA_BUS               r_store;
  alu_ctrl               r_ctrl;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_valid;

  logic                  w_wb_commit;
  DATA_BUS               w_rd1;
  DATA_BUS               w_rd2;
  DATA_BUS               w_op2;

  // A writeback commits only to a non-zero index; x0 stays hard-wired to zero.
  assign w_wb_commit = wb_en && (wb_addr != '0);

  // Register file: writeback commits regardless of stall or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_commit) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Combinational reads with x0 forced to zero and same-cycle writeback forwarded.
  always_comb begin
    w_rd1 = r_regs[rs1];
    if (rs1 == '0) begin
      w_rd1 = '0;
    end else if (w_wb_commit && (wb_addr == rs1)) begin
      w_rd1 = wb_data;
    end

    w_rd2 = r_regs[rs2];
    if (rs2 == '0) begin
      w_rd2 = '0;
    end else if (w_wb_commit && (wb_addr == rs2)) begin
      w_rd2 = wb_data;
    end

    w_op2 = alu_src ? imm : w_rd2;
  end

  // ID/EX register: flush inserts a bubble and beats stall; stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_store <= '0;
      r_ctrl  <= SUM_OP;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_store <= '0;
      r_ctrl  <= SUM_OP;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_op1   <= w_rd1;
      r_op2   <= w_op2;
      r_store <= w_rd2;
      r_ctrl  <= alu_ctrl_in;
      r_rd    <= rd_in;
      r_valid <= in_valid;
    end
  end

  assign ALUop1     = r_op1;
  assign ALUop2     = r_op2;
  assign store_data = r_store;
  assign ALUctrl    = r_ctrl;
  assign rd_out     = r_rd;
  assign ex_valid   = r_valid;

  // Debug view of x10 straight from the register file.
  assign a0 = r_regs[A0_IDX];

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Holds the 32-entry architectural register file and reads rs1/rs2.
- Selects the second operand: register or pre-extended immediate.
- Registers ALUop1, ALUop2 and ALUctrl into an ID/EX pipeline register that drives the ALU inputs, with stall and flush control.

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, width of DATA_BUS from types_pkg; fixed to match the ALU.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present this cycle.
- rs1  in  5  source register 1 index.
- rs2  in  5  source register 2 index.
- rd_in  in  5  destination index, passed through.
- imm  in  32  sign-extended immediate from decode.
- alu_src  in  1  0: op2 = reg[rs2]; 1: op2 = imm.
- alu_ctrl_in  in  alu_ctrl  operation code, passed through.
- stall  in  1  hold the pipeline register.
- flush  in  1  load a bubble into the pipeline register.
- wb_en  in  1  writeback enable.
- wb_addr  in  5  writeback index.
- wb_data  in  32  writeback value.
- ALUop1  out  32  registered operand 1.
- ALUop2  out  32  registered operand 2.
- ALUctrl  out  alu_ctrl  registered operation.
- store_data  out  32  registered reg[rs2], always the register value regardless of alu_src.
- rd_out  out  5  registered destination.
- ex_valid  out  1  registered valid.
- a0  out  32  combinational view of x10, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 32 registers clear to 0.
  - ALUop1, ALUop2, store_data = 0; rd_out = 0; ex_valid = 0; ALUctrl = SUM_OP.
  - Reset asserted mid-stall or mid-flush overrides both immediately.
- Register file:
  - Written on the rising edge when wb_en = 1 and wb_addr != 0.
  - Writes to x0 are discarded; reads of x0 always return 0.
  - Reads are combinational.
- Write-through bypass: if wb_en = 1, wb_addr != 0 and wb_addr == rs1 (or rs2) in the same cycle, the read returns wb_data, not the stale value.
- Operand select:
  - op1 = rd1.
  - op2 = alu_src ? imm : rd2.
  - store_data source = rd2, bypass included.
- Pipeline register update on each rising edge, in priority order:
  1. flush = 1: bubble. ex_valid = 0; ALUop1, ALUop2, store_data = 0; rd_out = 0; ALUctrl = SUM_OP. Flush wins over stall.
  2. stall = 1: all outputs hold their current values.
  3. Otherwise: load op1, op2, store_data, rd_in, alu_ctrl_in; ex_valid = in_valid.
- When in_valid = 0 and no stall/flush, operand fields still load (don't-care), but ex_valid = 0.
- Latency: one cycle from inputs to ALU-facing outputs.
- The register file write is independent of stall and flush: writeback still commits during both.
- No arithmetic is performed in this stage; widths pass through unchanged.

Test Plan:
- Reset: pulse rst_n low between edges -> all outputs 0 immediately, ALUctrl = SUM_OP, a0 = 0; no clock edge required.
- Write/read: wb x5 = 0x0000_00AA, next cycle rs1 = 5, rs2 = 0, alu_src = 0, SUB_OP -> after one edge ALUop1 = 0xAA, ALUop2 = 0, ALUctrl = SUB_OP, ex_valid = 1.
- x0 and bypass:
  - wb x0 = 0xFFFF_FFFF, then read rs1 = 0 -> ALUop1 = 0.
  - Same cycle wb x7 = 0x1234 with rs2 = 7, alu_src = 0 -> ALUop2 = 0x1234 and store_data = 0x1234.
- Immediate select: x3 = 9, rs2 = 3, alu_src = 1, imm = 0xFFFF_FFFC -> ALUop2 = 0xFFFF_FFFC, store_data = 9.
- Stall/flush:
  - Load an AND_OP instruction, then stall = 1 for 3 cycles while changing inputs -> outputs unchanged.
  - Assert stall and flush together -> bubble: ex_valid = 0, ALUctrl = SUM_OP, operands 0.
- Writeback under stall: stall = 1 while wb x10 = 0x55 -> a0 = 0x55 on the next cycle; pipeline outputs still held.
